// File: rtl/sdram_device_responder.sv
// -----------------------------------------------------------------------------
// sdram_device_responder
// Memory end of an SDR SDRAM command bus. Decodes CS/RAS/CAS/WE commands,
// keeps the mode register (CAS latency, burst length) and per-bank open rows,
// stores write bursts with byte masks, and returns read bursts after CL.
//
// Optional feature: define SDRAM_RESP_PROT_CHECK_EN to build the protocol
// checker that drives prot_err. Without it prot_err is tied low.
//
// Ports
//   clk            rising-edge clock shared with the controller
//   rst            asynchronous active-high reset
//   clock_enable   CKE; low freezes command decode, bursts, pipeline, outputs
//   cs_n           chip select, active low
//   ras_n/cas_n/we_n command bits
//   addr           row / column / mode value
//   bank_addr      bank select
//   dq_in          write data
//   data_mask_low  1 = keep old byte [7:0] on a write beat
//   data_mask_high 1 = keep old byte [15:8] on a write beat
//   dq_out         read data (registered)
//   dq_oe          1 = responder drives the data bus (registered)
//   refresh_count  AUTO_REFRESH commands since reset, wraps
//   prot_err       sticky protocol-violation flag
// -----------------------------------------------------------------------------
module sdram_device_responder #(
   parameter int unsigned ROW_WIDTH     = 13,
   parameter int unsigned COL_WIDTH     = 9,
   parameter int unsigned BANK_WIDTH    = 2,
   parameter int unsigned SDRADDR_WIDTH = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH,
   parameter int unsigned MEM_ROW_BITS  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clock_enable,
   input  logic                     cs_n,
   input  logic                     ras_n,
   input  logic                     cas_n,
   input  logic                     we_n,
   input  logic [SDRADDR_WIDTH-1:0] addr,
   input  logic [BANK_WIDTH-1:0]    bank_addr,
   input  logic [15:0]              dq_in,
   input  logic                     data_mask_low,
   input  logic                     data_mask_high,
   output logic [15:0]              dq_out,
   output logic                     dq_oe,
   output logic [15:0]              refresh_count,
   output logic                     prot_err
);

   localparam int unsigned NUM_BANKS = 1 << BANK_WIDTH;
   localparam int unsigned MEM_AW    = BANK_WIDTH + MEM_ROW_BITS + COL_WIDTH;
   localparam int unsigned MEM_DEPTH = 1 << MEM_AW;

   typedef enum logic [2:0] {
      CMD_MRS = 3'b000,
      CMD_REF = 3'b001,
      CMD_PRE = 3'b010,
      CMD_ACT = 3'b011,
      CMD_WR  = 3'b100,
      CMD_RD  = 3'b101,
      CMD_BT  = 3'b110,
      CMD_NOP = 3'b111
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_e;

   // Burst FSM and mode register
   state_e                  state_q, state_d;
   logic                    cl2_q, cl2_d;
   logic [1:0]              bl_log_q, bl_log_d;
   logic [15:0]             refresh_d;

   // Active burst context (used for beats after the command edge)
   logic [BANK_WIDTH-1:0]   b_bank_q, b_bank_d;
   logic [MEM_ROW_BITS-1:0] b_row_q, b_row_d;
   logic [COL_WIDTH-1:0]    b_col_q, b_col_d;
   logic [1:0]              b_bl_q, b_bl_d;
   logic [2:0]              beat_q, beat_d;

   // Read-data pipeline ahead of the output register
   logic                    s1_v_q, s1_v_d, s2_v_q, s2_v_d;
   logic [15:0]             s1_q, s1_d, s2_q, s2_d;
   logic                    dq_oe_d;
   logic [15:0]             dq_out_d;

   logic [ROW_WIDTH-1:0]    open_row_q [NUM_BANKS];
   logic [15:0]             mem [MEM_DEPTH];

   cmd_e                    cmd_c;
   logic                    issue_c, issue_wr_c, flush_c, act_c;
   logic [BANK_WIDTH-1:0]   issue_bank_c;
   logic [MEM_ROW_BITS-1:0] issue_row_c;
   logic [COL_WIDTH-1:0]    issue_base_c, col_mask_c, issue_col_c;
   logic [1:0]              issue_bl_c;
   logic [2:0]              issue_beat_c, last_beat_c;
   logic [MEM_AW-1:0]       mem_idx_c;
   logic [15:0]             mem_rd_c;
   logic                    mem_we_lo_c, mem_we_hi_c;
   logic                    unused_row_bits_c;

   // Command decode; deselect reads as NOP
   always_comb begin
      cmd_c = cs_n ? CMD_NOP : cmd_e'({ras_n, cas_n, we_n});
   end

   // Select the beat issued on this edge: a new READ/WRITE restarts, BURST_TERM
   // and PRECHARGE stop, otherwise a running burst continues
   always_comb begin
      issue_c      = 1'b0;
      issue_wr_c   = 1'b0;
      issue_bank_c = b_bank_q;
      issue_row_c  = b_row_q;
      issue_base_c = b_col_q;
      issue_bl_c   = b_bl_q;
      issue_beat_c = beat_q;
      if (clock_enable) begin
         if (cmd_c == CMD_RD || cmd_c == CMD_WR) begin
            issue_c      = 1'b1;
            issue_wr_c   = (cmd_c == CMD_WR);
            issue_bank_c = bank_addr;
            issue_row_c  = open_row_q[bank_addr][MEM_ROW_BITS-1:0];
            issue_base_c = addr[COL_WIDTH-1:0];
            issue_bl_c   = bl_log_q;
            issue_beat_c = 3'd0;
         end else if (cmd_c != CMD_BT && cmd_c != CMD_PRE && state_q != ST_IDLE) begin
            issue_c    = 1'b1;
            issue_wr_c = (state_q == ST_WRITE);
         end
      end
   end

   // Column wraps inside the BL-aligned block
   always_comb begin
      last_beat_c = 3'((4'd1 << issue_bl_c) - 4'd1);
      col_mask_c  = COL_WIDTH'(last_beat_c);
      issue_col_c = (issue_base_c & ~col_mask_c) |
                    ((issue_base_c + COL_WIDTH'(issue_beat_c)) & col_mask_c);
      mem_idx_c   = {issue_bank_c, issue_row_c, issue_col_c};
      mem_rd_c    = mem[mem_idx_c];
      mem_we_lo_c = issue_c & issue_wr_c & ~data_mask_low  & ~rst;
      mem_we_hi_c = issue_c & issue_wr_c & ~data_mask_high & ~rst;
   end

   // Next-state: burst FSM, mode register, refresh counter, read pipeline
   always_comb begin
      state_d   = state_q;
      cl2_d     = cl2_q;
      bl_log_d  = bl_log_q;
      refresh_d = refresh_count;
      b_bank_d  = b_bank_q;
      b_row_d   = b_row_q;
      b_col_d   = b_col_q;
      b_bl_d    = b_bl_q;
      beat_d    = beat_q;
      s1_v_d    = s1_v_q;
      s1_d      = s1_q;
      s2_v_d    = s2_v_q;
      s2_d      = s2_q;
      dq_oe_d   = dq_oe;
      dq_out_d  = dq_out;
      act_c     = 1'b0;
      flush_c   = 1'b0;
      if (clock_enable) begin
         case (cmd_c)
            CMD_MRS: begin
               cl2_d    = (addr[6:4] == 3'd2);
               bl_log_d = addr[2] ? 2'd0 : addr[1:0];
            end
            CMD_REF: refresh_d = refresh_count + 16'd1;
            CMD_ACT: act_c = 1'b1;
            CMD_WR:  flush_c = 1'b1;
            default: ;
         endcase

         if (issue_c) begin
            b_bank_d = issue_bank_c;
            b_row_d  = issue_row_c;
            b_col_d  = issue_base_c;
            b_bl_d   = issue_bl_c;
            beat_d   = issue_beat_c + 3'd1;
            if (issue_beat_c == last_beat_c) state_d = ST_IDLE;
            else state_d = issue_wr_c ? ST_WRITE : ST_READ;
         end else begin
            state_d = ST_IDLE;
         end

         // A WRITE discards read beats still in flight
         s1_v_d = issue_c & ~issue_wr_c;
         s1_d   = mem_rd_c;
         s2_v_d = s1_v_q & ~flush_c;
         s2_d   = s1_q;
         if (cl2_q) begin
            dq_oe_d  = s1_v_q & ~flush_c;
            dq_out_d = dq_oe_d ? s1_q : 16'd0;
         end else begin
            dq_oe_d  = s2_v_q & ~flush_c;
            dq_out_d = dq_oe_d ? s2_q : 16'd0;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cl2_q         <= 1'b0;
         bl_log_q      <= 2'd0;
         refresh_count <= 16'd0;
         b_bank_q      <= '0;
         b_row_q       <= '0;
         b_col_q       <= '0;
         b_bl_q        <= 2'd0;
         beat_q        <= 3'd0;
         s1_v_q        <= 1'b0;
         s1_q          <= 16'd0;
         s2_v_q        <= 1'b0;
         s2_q          <= 16'd0;
         dq_oe         <= 1'b0;
         dq_out        <= 16'd0;
      end else begin
         state_q       <= state_d;
         cl2_q         <= cl2_d;
         bl_log_q      <= bl_log_d;
         refresh_count <= refresh_d;
         b_bank_q      <= b_bank_d;
         b_row_q       <= b_row_d;
         b_col_q       <= b_col_d;
         b_bl_q        <= b_bl_d;
         beat_q        <= beat_d;
         s1_v_q        <= s1_v_d;
         s1_q          <= s1_d;
         s2_v_q        <= s2_v_d;
         s2_q          <= s2_d;
         dq_oe         <= dq_oe_d;
         dq_out        <= dq_out_d;
      end
   end

   // Per-bank latched row; survives PRECHARGE so closed-bank access reuses it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_BANKS; i++) open_row_q[i] <= '0;
      end else if (act_c) begin
         open_row_q[bank_addr] <= addr[ROW_WIDTH-1:0];
      end
   end

   // Only the low row bits address storage; upper bits alias
   always_comb begin
      unused_row_bits_c = 1'b0;
      for (int unsigned i = 0; i < NUM_BANKS; i++)
         unused_row_bits_c = unused_row_bits_c ^ (^open_row_q[i][ROW_WIDTH-1:MEM_ROW_BITS]);
   end

   // Storage with byte-lane write enables; contents not cleared by reset
   always_ff @(posedge clk) begin
      if (mem_we_lo_c) mem[mem_idx_c][7:0]  <= dq_in[7:0];
      if (mem_we_hi_c) mem[mem_idx_c][15:8] <= dq_in[15:8];
   end

`ifdef SDRAM_RESP_PROT_CHECK_EN
   logic [NUM_BANKS-1:0] bank_open_q, bank_open_d;
   logic                 rd_pending_c, prot_hit_c;

   // Bank open tracking and violation detection
   always_comb begin
      bank_open_d  = bank_open_q;
      rd_pending_c = (state_q == ST_READ) | s1_v_q | (~cl2_q & s2_v_q);
      prot_hit_c   = 1'b0;
      if (clock_enable) begin
         case (cmd_c)
            CMD_ACT: begin
               prot_hit_c             = bank_open_q[bank_addr];
               bank_open_d[bank_addr] = 1'b1;
            end
            CMD_PRE: begin
               if (addr[10]) bank_open_d = '0;
               else bank_open_d[bank_addr] = 1'b0;
            end
            CMD_RD, CMD_WR: prot_hit_c = ~bank_open_q[bank_addr];
            default: ;
         endcase
         if (rd_pending_c && !(cmd_c inside {CMD_NOP, CMD_BT, CMD_RD, CMD_WR}))
            prot_hit_c = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_open_q <= '0;
         prot_err    <= 1'b0;
      end else begin
         bank_open_q <= bank_open_d;
         if (prot_hit_c) prot_err <= 1'b1;
      end
   end
`else
   assign prot_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_device_responder.sv
// -----------------------------------------------------------------------------
// tb_sdram_device_responder
// Table of per-edge commands with expected dq_oe/dq_out after each edge, plus
// hand-written sequences for reset, refresh counting, async reset mid-burst
// and the protocol flag.
// -----------------------------------------------------------------------------
module tb_sdram_device_responder;

   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_BT  = 4'b0110;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_MRS = 4'b0000;
   localparam logic [3:0] C_DES = 4'b1111;

`ifdef SDRAM_RESP_PROT_CHECK_EN
   localparam logic PROT_ON = 1'b1;
`else
   localparam logic PROT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        clock_enable;
   logic        cs_n, ras_n, cas_n, we_n;
   logic [12:0] addr;
   logic [1:0]  bank_addr;
   logic [15:0] dq_in;
   logic        data_mask_low, data_mask_high;
   logic [15:0] dq_out;
   logic        dq_oe;
   logic [15:0] refresh_count;
   logic        prot_err;

   int total  = 0;
   int passed = 0;

   typedef struct {
      logic        cke;
      logic [3:0]  cmd;
      logic [12:0] a;
      logic [1:0]  b;
      logic [15:0] d;
      logic        ml;
      logic        mh;
      logic        eoe;
      logic [15:0] edq;
   } vec_t;

   vec_t vecs[$];

   sdram_device_responder dut (
      .clk            (clk),
      .rst            (rst),
      .clock_enable   (clock_enable),
      .cs_n           (cs_n),
      .ras_n          (ras_n),
      .cas_n          (cas_n),
      .we_n           (we_n),
      .addr           (addr),
      .bank_addr      (bank_addr),
      .dq_in          (dq_in),
      .data_mask_low  (data_mask_low),
      .data_mask_high (data_mask_high),
      .dq_out         (dq_out),
      .dq_oe          (dq_oe),
      .refresh_count  (refresh_count),
      .prot_err       (prot_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      else passed++;
   endtask

   task automatic drive(input logic cke, input logic [3:0] cmd, input logic [12:0] a,
                        input logic [1:0] b, input logic [15:0] d, input logic ml, input logic mh);
      clock_enable = cke;
      {cs_n, ras_n, cas_n, we_n} = cmd;
      addr = a;
      bank_addr = b;
      dq_in = d;
      data_mask_low = ml;
      data_mask_high = mh;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic add(input logic cke, input logic [3:0] cmd, input logic [12:0] a, input logic [1:0] b,
                      input logic [15:0] d, input logic ml, input logic mh, input logic eoe, input logic [15:0] edq);
      vec_t v;
      v.cke = cke; v.cmd = cmd; v.a = a; v.b = b; v.d = d;
      v.ml = ml; v.mh = mh; v.eoe = eoe; v.edq = edq;
      vecs.push_back(v);
   endtask

   // NOP row with an expected output
   task automatic nop(input logic eoe, input logic [15:0] edq);
      add(1'b1, C_NOP, 13'h0, 2'd0, 16'h0, 1'b0, 1'b0, eoe, edq);
   endtask

   // NOP row carrying write-beat data, bus expected idle
   task automatic wdat(input logic [15:0] d, input logic ml, input logic mh);
      add(1'b1, C_NOP, 13'h0, 2'd0, d, ml, mh, 1'b0, 16'h0);
   endtask

   task automatic cmd(input logic [3:0] c, input logic [12:0] a, input logic [1:0] b, input logic [15:0] d,
                      input logic mh, input logic eoe, input logic [15:0] edq);
      add(1'b1, c, a, b, d, 1'b0, mh, eoe, edq);
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b1, C_NOP, 13'h0, 2'd0, 16'h0, 1'b0, 1'b0);

      // Defaults CL3 BL1: read valid three edges after command
      cmd(C_ACT, 13'h000, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0);
      cmd(C_WR,  13'h000, 2'd0, 16'hBEEF, 1'b0, 1'b0, 16'h0);
      cmd(C_RD,  13'h000, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0);
      nop(1'b0, 16'h0); nop(1'b1, 16'hBEEF); nop(1'b0, 16'h0);
      // CL3 BL4 wrapped burst write at col6, read from col4
      cmd(C_MRS, 13'h032, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0);
      cmd(C_ACT, 13'h005, 2'd1, 16'h0000, 1'b0, 1'b0, 16'h0);
      cmd(C_WR,  13'h006, 2'd1, 16'h1111, 1'b0, 1'b0, 16'h0);
      wdat(16'h2222, 1'b0, 1'b0); wdat(16'h3333, 1'b0, 1'b0); wdat(16'h4444, 1'b0, 1'b0);
      cmd(C_RD,  13'h004, 2'd1, 16'h0000, 1'b0, 1'b0, 16'h0);
      nop(1'b0, 16'h0);
      nop(1'b1, 16'h3333); nop(1'b1, 16'h4444); nop(1'b1, 16'h1111); nop(1'b1, 16'h2222);
      nop(1'b0, 16'h0);
      // Read after PRECHARGE all still uses latched row 5
      cmd(C_PRE, 13'h400, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0);
      cmd(C_RD,  13'h004, 2'd1, 16'h0000, 1'b0, 1'b0, 16'h0);
      nop(1'b0, 16'h0);
      nop(1'b1, 16'h3333); nop(1'b1, 16'h4444); nop(1'b1, 16'h1111); nop(1'b1, 16'h2222);
      nop(1'b0, 16'h0);
      // CL2 BL1: single beat two edges after command
      cmd(C_MRS, 13'h020, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0);
      cmd(C_ACT, 13'h000, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0);
      cmd(C_WR,  13'h010, 2'd0, 16'hA5A5, 1'b0, 1'b0, 16'h0);
      cmd(C_RD,  13'h010, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0);
      nop(1'b1, 16'hA5A5); nop(1'b0, 16'h0);
      // BL4 byte masks over an all-ones block
      cmd(C_MRS, 13'h032, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0);
      cmd(C_WR,  13'h000, 2'd0, 16'hFFFF, 1'b0, 1'b0, 16'h0);
      wdat(16'hFFFF, 1'b0, 1'b0); wdat(16'hFFFF, 1'b0, 1'b0); wdat(16'hFFFF, 1'b0, 1'b0);
      cmd(C_WR,  13'h000, 2'd0, 16'h1234, 1'b1, 1'b0, 16'h0);
      wdat(16'h1234, 1'b0, 1'b1); wdat(16'h1234, 1'b0, 1'b1); wdat(16'h1234, 1'b1, 1'b0);
      cmd(C_RD,  13'h000, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0);
      nop(1'b0, 16'h0);
      nop(1'b1, 16'hFF34); nop(1'b1, 16'hFF34); nop(1'b1, 16'hFF34); nop(1'b1, 16'h12FF);
      nop(1'b0, 16'h0);
      // CL3 BL8: BURST_TERM two edges after first beat appears -> four beats
      cmd(C_MRS, 13'h033, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0);
      cmd(C_WR,  13'h008, 2'd0, 16'h0800, 1'b0, 1'b0, 16'h0);
      for (int k = 1; k < 8; k++) wdat(16'h0800 + 16'(k), 1'b0, 1'b0);
      cmd(C_RD,  13'h008, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0);
      nop(1'b0, 16'h0);
      nop(1'b1, 16'h0800); nop(1'b1, 16'h0801);
      cmd(C_BT,  13'h000, 2'd0, 16'h0000, 1'b0, 1'b1, 16'h0802);
      nop(1'b1, 16'h0803); nop(1'b0, 16'h0); nop(1'b0, 16'h0);
      // WRITE while read beats emerge: bus released, write burst proceeds
      cmd(C_RD,  13'h008, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0);
      nop(1'b0, 16'h0); nop(1'b1, 16'h0800);
      cmd(C_WR,  13'h020, 2'd0, 16'h7777, 1'b0, 1'b0, 16'h0);
      for (int k = 1; k < 8; k++) wdat(16'h7777, 1'b0, 1'b0);
      cmd(C_RD,  13'h022, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0);
      nop(1'b0, 16'h0); nop(1'b1, 16'h7777); nop(1'b1, 16'h7777);
      cmd(C_BT,  13'h000, 2'd0, 16'h0000, 1'b0, 1'b1, 16'h7777);
      nop(1'b1, 16'h7777); nop(1'b0, 16'h0);
      // Clock suspend mid-read: ignored WRITE, outputs and burst frozen
      cmd(C_RD,  13'h008, 2'd0, 16'h0000, 1'b0, 1'b0, 16'h0);
      nop(1'b0, 16'h0); nop(1'b1, 16'h0800);
      add(1'b0, C_WR,  13'h008, 2'd0, 16'hDEAD, 1'b0, 1'b0, 1'b1, 16'h0800);
      add(1'b0, C_NOP, 13'h000, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0800);
      nop(1'b1, 16'h0801); nop(1'b1, 16'h0802);
      cmd(C_BT,  13'h000, 2'd0, 16'h0000, 1'b0, 1'b1, 16'h0803);
      nop(1'b1, 16'h0804); nop(1'b0, 16'h0);

      step(); step();
      rst = 1'b0;
      chk("rst_oe", 0, 16'(dq_oe), 16'h0);
      chk("rst_dq", 0, dq_out, 16'h0);
      chk("rst_refresh", 0, refresh_count, 16'h0);
      chk("rst_prot", 0, 16'(prot_err), 16'h0);

      foreach (vecs[i]) begin
         drive(vecs[i].cke, vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].ml, vecs[i].mh);
         step();
         chk("oe", i, 16'(dq_oe), 16'(vecs[i].eoe));
         if (vecs[i].eoe) chk("dq", i, dq_out, vecs[i].edq);
      end
      drive(1'b1, C_NOP, 13'h0, 2'd0, 16'h0, 1'b0, 1'b0);
      chk("table_prot", 0, 16'(prot_err), 16'(PROT_ON));

      // Refresh counting: deselect and clock suspend do not count
      chk("ref0", 0, refresh_count, 16'd0);
      drive(1'b1, C_REF, 13'h0, 2'd0, 16'h0, 1'b0, 1'b0); step();
      chk("ref1", 0, refresh_count, 16'd1);
      drive(1'b1, C_DES & 4'b1001 | 4'b1000, 13'h0, 2'd0, 16'h0, 1'b0, 1'b0); step();
      chk("ref_des", 0, refresh_count, 16'd1);
      drive(1'b0, C_REF, 13'h0, 2'd0, 16'h0, 1'b0, 1'b0); step();
      chk("ref_cke0", 0, refresh_count, 16'd1);
      drive(1'b1, C_REF, 13'h0, 2'd0, 16'h0, 1'b0, 1'b0); step();
      chk("ref2", 0, refresh_count, 16'd2);

      // Async reset while a read beat is on the bus
      drive(1'b1, C_RD, 13'h008, 2'd0, 16'h0, 1'b0, 1'b0); step();
      drive(1'b1, C_NOP, 13'h0, 2'd0, 16'h0, 1'b0, 1'b0); step(); step();
      chk("pre_rst_oe", 0, 16'(dq_oe), 16'h1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_oe", 0, 16'(dq_oe), 16'h0);
      chk("async_rst_dq", 0, dq_out, 16'h0);
      step();
      rst = 1'b0;
      chk("rst2_refresh", 0, refresh_count, 16'h0);
      chk("rst2_prot", 0, 16'(prot_err), 16'h0);

      // Mode back to CL3 BL1; memory kept; ignored suspended WRITE left col8 intact
      drive(1'b1, C_ACT, 13'h000, 2'd0, 16'h0, 1'b0, 1'b0); step();
      drive(1'b1, C_RD, 13'h008, 2'd0, 16'h0, 1'b0, 1'b0); step();
      chk("post_rst_oe", 0, 16'(dq_oe), 16'h0);
      drive(1'b1, C_NOP, 13'h0, 2'd0, 16'h0, 1'b0, 1'b0); step();
      chk("post_rst_oe", 1, 16'(dq_oe), 16'h0);
      step();
      chk("post_rst_oe", 2, 16'(dq_oe), 16'h1);
      chk("post_rst_dq", 2, dq_out, 16'h0800);
      step();
      chk("post_rst_oe", 3, 16'(dq_oe), 16'h0);

      // Protocol flag: READ to closed bank, then legal traffic, then reset
      drive(1'b1, C_PRE, 13'h400, 2'd0, 16'h0, 1'b0, 1'b0); step();
      chk("prot_pre", 0, 16'(prot_err), 16'h0);
      drive(1'b1, C_RD, 13'h000, 2'd2, 16'h0, 1'b0, 1'b0); step();
      chk("prot_rd_closed", 0, 16'(prot_err), 16'(PROT_ON));
      drive(1'b1, C_NOP, 13'h0, 2'd0, 16'h0, 1'b0, 1'b0); step(); step(); step();
      drive(1'b1, C_ACT, 13'h003, 2'd2, 16'h0, 1'b0, 1'b0); step();
      drive(1'b1, C_NOP, 13'h0, 2'd0, 16'h0, 1'b0, 1'b0); step();
      chk("prot_sticky", 0, 16'(prot_err), 16'(PROT_ON));
      rst = 1'b1;
      #1;
      chk("prot_cleared", 0, 16'(prot_err), 16'h0);
      step();
      rst = 1'b0;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
